flagged_packet_writer: RTL and testbench
========================================

# flagged_packet_writer

Downstream capture stage for the Ethernet sniffer. Buffers each Avalon-ST packet leaving the comparator pipeline, ORs in the match pulses from the port/IP/MAC/URL comparators, and decides per packet. A flagged, error-free packet is written word by word, preceded by a descriptor word, into a circular memory region through an Avalon-MM write master. Any other packet is discarded and counted.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of the capture region; word-aligned.
- REGION_WORDS, 1024: region size in 32-bit words; power of two.
- DEPTH, 512: packet buffer size in words; must be at least 380, which holds a 1518-byte frame.
- HIT_SLACK, 4: cycles after eop during which flag_hit is still accepted.
- clk  in  1: system clock.
- n_rst  in  1: asynchronous, active-low reset.
- data_in  in  32: packet word, first byte in bits [31:24].
- valid_in  in  1: word qualifier.
- sop_in  in  1: first word of packet; qualified by valid_in.
- eop_in  in  1: last word of packet; qualified by valid_in.
- empty_in  in  2: unused bytes in the eop word.
- error_in  in  6: nonzero at eop marks a bad packet.
- flag_hit  in  1: single-cycle match pulse from any comparator.
- mm_waitrequest  in  1: Avalon-MM stall.
- ready_out  out  1: upstream may present words.
- addr_out  out  32: Avalon-MM byte address.
- write_enable  out  1: Avalon-MM write.
- data_out  out  32: Avalon-MM write data.
- packets_written  out  32: count of committed packets.
- packets_dropped  out  32: count of discarded packets.

## Operation
- States: IDLE, CAPTURE, WAIT_FLAG, WRITE.
- IDLE:
  - ready_out=1.
  - valid_in&sop_in stores the word at buffer index 0, sets wcnt=1 and sets hit=flag_hit.
  - If eop_in is also set, go to WAIT_FLAG; otherwise go to CAPTURE.
  - valid words without sop are ignored.
- CAPTURE:
  - ready_out=1. Each valid word is stored at index wcnt and wcnt increments. hit |= flag_hit every cycle.
  - valid&eop: store the word, latch empty_in, latch bad=(error_in!=0), go to WAIT_FLAG.
  - valid&sop, which means eop was missing: the current packet is dropped (packets_dropped++) and the new packet restarts at index 0.
  - wcnt reaching DEPTH sets trunc. Further words are discarded, but eop is still tracked.
- WAIT_FLAG:
  - ready_out=0. Counts HIT_SLACK cycles while hit |= flag_hit continues.
  - On the final count: if hit&!bad&!trunc, go to WRITE. Otherwise packets_dropped++ and go to IDLE.
- WRITE:
  - ready_out=0.
  - Beat 0 is the descriptor {wcnt[15:0], 14'b0, empty[1:0]}. Beats 1..wcnt are the buffered words in order.
  - Each beat: write_enable=1 and addr_out=BASE_ADDR+4*wptr. addr_out and data_out are held stable while mm_waitrequest=1.
  - A beat completes on a cycle with write_enable&!mm_waitrequest. wptr then increments modulo REGION_WORDS, wrapping to BASE_ADDR.
  - After the last beat completes: packets_written++, write_enable=0, go to IDLE.
- wptr persists across packets. Successive packets are packed contiguously.
- Counters are 32-bit and wrap.

## Timing
- Reset values: ready_out=0 during reset and 1 in the first cycle after release. addr_out=BASE_ADDR, write_enable=0, data_out=0, both counters=0, wptr=0, state IDLE.
- Reset asserted mid-packet or mid-write aborts at once. No counter is incremented for the aborted packet.
- WAIT_FLAG lasts exactly HIT_SLACK cycles. A flag_hit in the eop cycle or in any WAIT_FLAG cycle counts. A flag_hit in IDLE with no sop is ignored.
- The descriptor beat appears the cycle after WAIT_FLAG ends.
- With mm_waitrequest=0, beats complete on consecutive cycles with no bubbles. A packet of N words occupies WRITE for N+1 cycles.
- A counter update is visible the cycle after the deciding edge.
- Address wrap applies per beat. A packet may straddle the region end.

## Test plan
- Reset, then idle: ready_out=1, write_enable=0, addr_out=BASE_ADDR, counters 0.
- 8-word packet, flag_hit pulsed at word 3, mm_waitrequest=0, empty_in=2'b01 → descriptor 32'h0008_0001 at BASE_ADDR. Then 8 words in order at +4..+32 on consecutive cycles, packets_written=1.
- Same 8-word packet with no flag_hit → no writes, packets_dropped=1, ready_out back to 1 after HIT_SLACK cycles.
- flag_hit 3 cycles after eop (HIT_SLACK=4) → packet written. flag_hit 5 cycles after eop → packet dropped.
- mm_waitrequest held high 3 cycles on beat 2 → addr_out and data_out stable across the stall, no beat skipped or duplicated.
- REGION_WORDS=16 with a 20-word flagged packet → descriptor at BASE_ADDR and words wrapping after offset 60 back to BASE_ADDR. Also: error_in=6'h01 at eop with flag_hit → packets_dropped increments and no write occurs.

Source files
------------

// File: rtl/flagged_packet_writer_if.sv
// Port bundles for flagged_packet_writer: Avalon-ST capture input (with comparator
// match pulse) and Avalon-MM write master output.
interface flagged_packet_writer_st_if;
  logic [31:0] data_in;
  logic        valid_in;
  logic        sop_in;
  logic        eop_in;
  logic [1:0]  empty_in;
  logic [5:0]  error_in;
  logic        flag_hit;
  logic        ready_out;

  modport master (
    output data_in, valid_in, sop_in, eop_in, empty_in, error_in, flag_hit,
    input  ready_out
  );

  modport slave (
    input  data_in, valid_in, sop_in, eop_in, empty_in, error_in, flag_hit,
    output ready_out
  );
endinterface

interface flagged_packet_writer_mm_if;
  logic [31:0] addr_out;
  logic        write_enable;
  logic [31:0] data_out;
  logic        mm_waitrequest;

  modport master (
    output addr_out, write_enable, data_out,
    input  mm_waitrequest
  );

  modport slave (
    input  addr_out, write_enable, data_out,
    output mm_waitrequest
  );
endinterface

// File: rtl/flagged_packet_writer.sv
// Buffers one Avalon-ST packet, collects comparator hits, and either writes it
// (descriptor + words) into a circular capture region or drops it.
module flagged_packet_writer #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned REGION_WORDS = 1024,
  parameter int unsigned DEPTH        = 512,
  parameter int unsigned HIT_SLACK    = 4
) (
  input  logic                              clk,
  input  logic                              n_rst,
  flagged_packet_writer_st_if.slave         st,
  flagged_packet_writer_mm_if.master        mm,
  output logic [31:0]                       packets_written,
  output logic [31:0]                       packets_dropped
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = (REGION_WORDS > 1) ? $clog2(REGION_WORDS) : 1;
  localparam int unsigned SW = (HIT_SLACK > 1) ? $clog2(HIT_SLACK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    WAIT_FLAG,
    WRITE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [SW-1:0]   slack_q, slack_d;
  logic            hit_q, hit_d;
  logic            bad_q, bad_d;
  logic            trunc_q, trunc_d;
  logic [1:0]      empty_q, empty_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [31:0]     written_q, written_d;
  logic [31:0]     dropped_q, dropped_d;
  logic            ready_q, ready_d;

  logic [31:0]     buf_mem [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_idx;
  logic [AW-1:0]   rd_idx;
  logic [31:0]     wdata;
  logic            start_pkt;

  assign start_pkt = st.valid_in && st.sop_in &&
                     ((state_q == IDLE) || (state_q == CAPTURE));

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    beat_d    = beat_q;
    slack_d   = slack_q;
    hit_d     = hit_q;
    bad_d     = bad_q;
    trunc_d   = trunc_q;
    empty_d   = empty_q;
    wptr_d    = wptr_q;
    written_d = written_q;
    dropped_d = dropped_q;
    mem_we    = 1'b0;
    mem_idx   = wcnt_q[AW-1:0];

    // A sop seen mid-packet means the previous eop was lost: drop it and restart here.
    if (start_pkt) begin
      mem_we  = 1'b1;
      mem_idx = '0;
      wcnt_d  = CW'(1);
      beat_d  = '0;
      slack_d = '0;
      hit_d   = st.flag_hit;
      trunc_d = (DEPTH == 1);
      bad_d   = st.eop_in && (st.error_in != '0);
      empty_d = st.eop_in ? st.empty_in : 2'b00;
      state_d = st.eop_in ? WAIT_FLAG : CAPTURE;
      if (state_q == CAPTURE) dropped_d = dropped_q + 32'd1;
    end else begin
      case (state_q)
        CAPTURE: begin
          hit_d = hit_q | st.flag_hit;
          if (st.valid_in) begin
            if (!trunc_q) begin
              mem_we = 1'b1;
              wcnt_d = wcnt_q + 1'b1;
              if (wcnt_q == CW'(DEPTH - 1)) trunc_d = 1'b1;
            end
            if (st.eop_in) begin
              empty_d = st.empty_in;
              bad_d   = (st.error_in != '0);
              slack_d = '0;
              state_d = WAIT_FLAG;
            end
          end
        end
        WAIT_FLAG: begin
          hit_d   = hit_q | st.flag_hit;
          slack_d = slack_q + 1'b1;
          if (slack_q == SW'(HIT_SLACK - 1)) begin
            if ((hit_q | st.flag_hit) && !bad_q && !trunc_q) begin
              beat_d  = '0;
              state_d = WRITE;
            end else begin
              dropped_d = dropped_q + 32'd1;
              state_d   = IDLE;
            end
          end
        end
        WRITE: begin
          if (!mm.mm_waitrequest) begin
            wptr_d = wptr_q + 1'b1;
            if (beat_q == wcnt_q) begin
              written_d = written_q + 32'd1;
              state_d   = IDLE;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    ready_d = (state_d == IDLE) || (state_d == CAPTURE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      beat_q    <= '0;
      slack_q   <= '0;
      hit_q     <= 1'b0;
      bad_q     <= 1'b0;
      trunc_q   <= 1'b0;
      empty_q   <= '0;
      wptr_q    <= '0;
      written_q <= '0;
      dropped_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      beat_q    <= beat_d;
      slack_q   <= slack_d;
      hit_q     <= hit_d;
      bad_q     <= bad_d;
      trunc_q   <= trunc_d;
      empty_q   <= empty_d;
      wptr_q    <= wptr_d;
      written_q <= written_d;
      dropped_q <= dropped_d;
      ready_q   <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) buf_mem[mem_idx] <= st.data_in;
  end

  // Beat 0 is the descriptor, so buffered word k goes out on beat k+1.
  assign rd_idx = AW'(beat_q - 1'b1);

  always_comb begin
    wdata = '0;
    if (state_q == WRITE) begin
      if (beat_q == '0) wdata = {16'(wcnt_q), 14'b0, empty_q};
      else              wdata = buf_mem[rd_idx];
    end
  end

  assign st.ready_out     = ready_q;
  assign mm.write_enable  = (state_q == WRITE);
  assign mm.addr_out      = BASE_ADDR + (32'(wptr_q) << 2);
  assign mm.data_out      = wdata;
  assign packets_written  = written_q;
  assign packets_dropped  = dropped_q;

endmodule

// File: tb/tb_flagged_packet_writer.sv
// Randomized scoreboard bench for flagged_packet_writer with a packet-level model.
module tb_flagged_packet_writer;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int unsigned RW   = 16;
  localparam int unsigned DP   = 512;
  localparam int unsigned HS   = 4;

  logic        clk   = 1'b0;
  logic        n_rst = 1'b1;
  logic [31:0] packets_written;
  logic [31:0] packets_dropped;

  flagged_packet_writer_st_if st ();
  flagged_packet_writer_mm_if mm ();

  flagged_packet_writer #(
    .BASE_ADDR    (BASE),
    .REGION_WORDS (RW),
    .DEPTH        (DP),
    .HIT_SLACK    (HS)
  ) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .st              (st.slave),
    .mm              (mm.master),
    .packets_written (packets_written),
    .packets_dropped (packets_dropped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned chk_cnt = 0;
  int unsigned pass_cnt = 0;
  int unsigned wm = 0;
  logic [31:0] wr_m = '0;
  logic [31:0] dr_m = '0;
  int unsigned cur_beat = 0;
  int unsigned total_stalls = 0;
  int unsigned stall_mode = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: scoreboard pops on every completed beat, stall stability checks.
  initial begin
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    beat_t       e;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        prev_stall = 1'b0;
        cur_beat   = 0;
      end else begin
        if (prev_stall && mm.write_enable) begin
          check(mm.addr_out == prev_addr, "stall_addr", mm.addr_out, prev_addr);
          check(mm.data_out == prev_data, "stall_data", mm.data_out, prev_data);
        end
        if (mm.write_enable && mm.mm_waitrequest) begin
          total_stalls++;
          prev_stall = 1'b1;
          prev_addr  = mm.addr_out;
          prev_data  = mm.data_out;
        end else begin
          prev_stall = 1'b0;
        end
        if (mm.write_enable && !mm.mm_waitrequest) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_write", mm.addr_out, 32'h0);
          end else begin
            e = exp_q.pop_front();
            check(mm.addr_out == e.addr, "beat_addr", mm.addr_out, e.addr);
            check(mm.data_out == e.data, "beat_data", mm.data_out, e.data);
          end
          cur_beat++;
        end else if (!mm.write_enable) begin
          cur_beat = 0;
        end
      end
    end
  end

  // Waitrequest driver: off, random, or a 3-cycle stall on beat 2.
  initial begin
    int unsigned left = 3;
    mm.mm_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (stall_mode)
        1: mm.mm_waitrequest = ($urandom_range(0, 2) == 0);
        2: begin
          if (!mm.write_enable) left = 3;
          if (mm.write_enable && cur_beat == 2 && left > 0) begin
            mm.mm_waitrequest = 1'b1;
            left--;
          end else begin
            mm.mm_waitrequest = 1'b0;
          end
        end
        default: mm.mm_waitrequest = 1'b0;
      endcase
    end
  end

  task automatic drive(input logic v, input logic s, input logic e, input logic [31:0] d,
                       input logic [1:0] emp, input logic [5:0] err, input logic f);
    @(posedge clk);
    #1;
    st.valid_in = v;
    st.sop_in   = s;
    st.eop_in   = e;
    st.data_in  = d;
    st.empty_in = emp;
    st.error_in = err;
    st.flag_hit = f;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    exp_q.delete();
    wm   = 0;
    wr_m = '0;
    dr_m = '0;
    #1;
    check(mm.write_enable == 1'b0, "rst_we_async", 32'(mm.write_enable), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check(st.ready_out == 1'b0, "rst_ready_low", 32'(st.ready_out), 32'h0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    check(st.ready_out == 1'b1, "post_rst_ready", 32'(st.ready_out), 32'h1);
    check(mm.write_enable == 1'b0, "post_rst_we", 32'(mm.write_enable), 32'h0);
    check(mm.addr_out == BASE, "post_rst_addr", mm.addr_out, BASE);
    check(mm.data_out == 32'h0, "post_rst_data", mm.data_out, 32'h0);
    check(packets_written == 32'h0, "post_rst_written", packets_written, 32'h0);
    check(packets_dropped == 32'h0, "post_rst_dropped", packets_dropped, 32'h0);
  endtask

  // Packet without eop; the next sop must discard it.
  task automatic send_partial(input int n, input int flag_word);
    for (int w = 0; w < n; w++)
      drive(1'b1, w == 0, 1'b0, $urandom, 2'b00, 6'h00, w == flag_word);
    dr_m = dr_m + 32'd1;
  endtask

  // fmode: 0 no hit, 1 hit on word fpar, 2 hit fpar cycles after eop (0 = eop cycle),
  // 3 hit in the idle cycle before sop (with a stray non-sop word).
  task automatic send_packet(input int n, input int fmode, input int fpar,
                             input logic [5:0] err, input logic [1:0] emp,
                             input bit gaps, input bit wait_first, input bit abort);
    logic [31:0] words[$];
    bit          hit, commit, done;
    int          w, low;
    int unsigned st0;
    for (int i = 0; i < n; i++) words.push_back($urandom);
    if (wait_first) begin
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
        if (st.ready_out) done = 1'b1;
        else drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 6'h00, 1'b0);
      end
      if (!done) check(1'b0, "ready_timeout", 32'h0, 32'h1);
    end
    if (fmode == 3) drive(1'b1, 1'b0, 1'b0, $urandom, 2'b00, 6'h00, 1'b1);
    w = 0;
    while (w < n) begin
      if (gaps && w > 0 && $urandom_range(0, 2) == 0) begin
        drive(1'b0, 1'b0, 1'b0, $urandom, 2'b00, 6'h00, 1'b0);
      end else begin
        drive(1'b1, w == 0, w == n - 1, words[w], (w == n - 1) ? emp : 2'b00,
              (w == n - 1) ? err : 6'h00,
              (fmode == 1 && fpar == w) || (fmode == 2 && fpar == 0 && w == n - 1));
        w++;
      end
    end
    hit    = (fmode == 1 && fpar < n) || (fmode == 2 && fpar <= int'(HS));
    commit = hit && (err == 6'h00);
    st0    = total_stalls;
    if (commit) begin
      exp_q.push_back('{BASE + 32'(wm) * 4, {16'(n), 14'b0, emp}});
      wm = (wm + 1) % RW;
      foreach (words[i]) begin
        exp_q.push_back('{BASE + 32'(wm) * 4, words[i]});
        wm = (wm + 1) % RW;
      end
      wr_m = wr_m + 32'd1;
    end else begin
      dr_m = dr_m + 32'd1;
    end
    if (abort) begin
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 6'h00, 1'b0);
        if (cur_beat >= 3) done = 1'b1;
      end
      if (!done) check(1'b0, "abort_beat_timeout", 32'(cur_beat), 32'd3);
      do_reset();
      return;
    end
    low = -1;
    for (int cyc = 1; cyc < 400; cyc++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 6'h00, fmode == 2 && fpar == cyc);
      if (st.ready_out && low < 0) low = cyc - 1;
      if (low >= 0 && !(fmode == 2 && fpar > cyc)) break;
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 6'h00, 1'b0);
    if (low < 0)
      check(1'b0, "busy_timeout", 32'h0, 32'h1);
    else
      check(low == int'(HS) + (commit ? n + 1 + int'(total_stalls - st0) : 0), "busy_cycles",
            32'(low), 32'(int'(HS) + (commit ? n + 1 + int'(total_stalls - st0) : 0)));
    check(packets_written == wr_m, "packets_written", packets_written, wr_m);
    check(packets_dropped == dr_m, "packets_dropped", packets_dropped, dr_m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, fm, fp;
    st.valid_in = 1'b0;
    st.sop_in   = 1'b0;
    st.eop_in   = 1'b0;
    st.data_in  = '0;
    st.empty_in = '0;
    st.error_in = '0;
    st.flag_hit = 1'b0;

    do_reset();
    stall_mode = 0;
    send_packet(8, 1, 3, 6'h00, 2'b01, 1'b0, 1'b1, 1'b0);
    send_packet(8, 0, 0, 6'h00, 2'b01, 1'b0, 1'b1, 1'b0);
    send_packet(8, 2, 3, 6'h00, 2'b10, 1'b0, 1'b1, 1'b0);
    send_packet(8, 2, 5, 6'h00, 2'b10, 1'b0, 1'b1, 1'b0);
    send_packet(8, 2, 4, 6'h00, 2'b00, 1'b0, 1'b1, 1'b0);
    send_packet(8, 2, 0, 6'h00, 2'b11, 1'b0, 1'b1, 1'b0);
    send_packet(8, 3, 0, 6'h00, 2'b00, 1'b0, 1'b1, 1'b0);
    stall_mode = 2;
    send_packet(8, 1, 5, 6'h00, 2'b01, 1'b0, 1'b1, 1'b0);
    stall_mode = 0;
    send_packet(6, 1, 2, 6'h01, 2'b00, 1'b0, 1'b1, 1'b0);
    send_partial(5, 1);
    send_packet(7, 0, 0, 6'h00, 2'b00, 1'b0, 1'b0, 1'b0);
    send_packet(1, 1, 0, 6'h00, 2'b10, 1'b0, 1'b1, 1'b0);

    stall_mode = 1;
    for (int k = 0; k < 25; k++) begin
      n  = $urandom_range(1, 24);
      fm = $urandom_range(0, 3);
      fp = (fm == 1) ? $urandom_range(0, n - 1) : $urandom_range(0, 6);
      send_packet(n, fm, fp, ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'h00,
                  2'($urandom), 1'($urandom), 1'b1, 1'b0);
    end

    stall_mode = 0;
    send_packet(10, 1, 0, 6'h00, 2'b00, 1'b0, 1'b1, 1'b1);
    send_packet(20, 1, 4, 6'h00, 2'b11, 1'b0, 1'b1, 1'b0);
    stall_mode = 1;
    send_packet(20, 2, 2, 6'h00, 2'b01, 1'b1, 1'b1, 1'b0);

    repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 6'h00, 1'b0);
    check(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
